tdm_frame_ctrl: RTL

Master-side clock and framing controller for the TDM microphone array. Divides the system clock to generate the serial bit clock (`sck_out`) and the one-bit-wide frame-sync pulse (`ws_out`) that drive the microphones and the TDM receiver. It sequences whole frames under a start/stop enable, so capture always begins and ends on frame boundaries. It also gives system-clock-domain strobes to downstream capture logic.

---
 rtl/tdm_frame_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tdm_frame_ctrl.sv
// rtl/tdm_frame_ctrl.sv - TDM master sck/ws generator with frame-aligned start/stop sequencing
// Optional frame counter is built only when TDM_FRAME_CNT_EN is defined.
module tdm_frame_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int SLOT_BITS   = 32,
  parameter int SLOTS       = 4,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  output logic                   sck_out,
  output logic                   ws_out,
  output logic                   sck_rise_out,
  output logic                   frame_start_out,
  output logic                   busy_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt_out
);

  localparam int FRAME = SLOTS * SLOT_BITS;
  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int BI_W  = $clog2(FRAME);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(FRAME - 1);
  localparam logic [BI_W-1:0] BI_STOP = BI_W'(FRAME - 2);

  generate
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("tdm_frame_ctrl: CLK_DIV must be even and >= 2");
    end
    if (FRAME < 2) begin : g_bad_frame
      $error("tdm_frame_ctrl: SLOTS*SLOT_BITS must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PH_W-1:0]   r_ph;
  logic [BI_W-1:0]   r_bi;
  logic              w_ph_wrap;
  logic              w_stop_pt;

  logic              w_sck_d;
  logic              w_ws_d;
  logic              w_busy_d;
  logic              r_sck;
  logic              r_ws;
  logic              r_busy;
  logic              r_sck_rise;
  logic              r_frame_start;

  assign w_ph_wrap = (r_ph == PH_LAST);
  // Stopping after the FRAME-2 period suppresses the ws that would start an unused frame.
  assign w_stop_pt = w_ph_wrap && (r_bi == BI_STOP);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable_in) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!enable_in) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (enable_in)      w_state_nxt = S_RUN;
        else if (w_stop_pt) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sck_d  = 1'b0;
    w_ws_d   = 1'b0;
    w_busy_d = 1'b0;
    if (r_state != S_IDLE) begin
      w_busy_d = 1'b1;
      w_sck_d  = (r_ph >= PH_HALF);
      w_ws_d   = (r_bi == BI_LAST);
    end
  end

  // A start preloads bi to the last bit so the first sck period is the ws preamble.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ph <= '0;
      r_bi <= '0;
    end else if (r_state == S_IDLE) begin
      if (enable_in) begin
        r_ph <= '0;
        r_bi <= BI_LAST;
      end
    end else begin
      r_ph <= w_ph_wrap ? '0 : r_ph + 1'b1;
      if (w_ph_wrap) begin
        r_bi <= (r_bi == BI_LAST) ? '0 : r_bi + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sck         <= 1'b0;
      r_ws          <= 1'b0;
      r_busy        <= 1'b0;
      r_sck_rise    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_sck         <= w_sck_d;
      r_ws          <= w_ws_d;
      r_busy        <= w_busy_d;
      r_sck_rise    <= w_sck_d & ~r_sck;
      r_frame_start <= w_ws_d & ~r_ws;
    end
  end

  assign sck_out         = r_sck;
  assign ws_out          = r_ws;
  assign busy_out        = r_busy;
  assign sck_rise_out    = r_sck_rise;
  assign frame_start_out = r_frame_start;

`ifdef TDM_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frame_cnt <= '0;
    end else if (w_ws_d && !r_ws) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt_out = r_frame_cnt;
`else
  assign frame_cnt_out = '0;
`endif

endmodule
